// File: rtl/ps2_kbd.sv
// PS/2 keyboard receiver with a scancode FIFO and a CPU read port.
// Bytes are framed from the synchronized PS/2 pins and queued for DATA reads.
module ps2_kbd #(
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT    = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  input  logic        sel,
  input  logic        re,
  input  logic [31:0] addr,
  output logic [31:0] dout
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE, RECV} state_t;

  logic [1:0]    ps2_clk_sync_q, ps2_data_sync_q;
  logic          ps2_clk_prev_q;
  state_t        state_q, state_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [9:0]    shift_q, shift_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d, ferr_q, ferr_d;
  logic [7:0]    mem_q [FIFO_DEPTH];

  logic fall, bit_in, frame_done, frame_ok;
  logic empty, full, pop, push, status_rd;
  logic unused_addr;

  assign unused_addr = ^{addr[31:3], addr[1:0]};
  assign fall        = ps2_clk_prev_q & ~ps2_clk_sync_q[1];
  assign bit_in      = ps2_data_sync_q[1];

  // Synchronizers idle high so a reset never fabricates a falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      ps2_clk_sync_q  <= 2'b11;
      ps2_data_sync_q <= 2'b11;
      ps2_clk_prev_q  <= 1'b1;
    end else begin
      ps2_clk_sync_q  <= {ps2_clk_sync_q[0], ps2_clk};
      ps2_data_sync_q <= {ps2_data_sync_q[0], ps2_data};
      ps2_clk_prev_q  <= ps2_clk_sync_q[1];
    end
  end

  // Frame receiver: shift_q holds start in [0], data in [8:1], parity in [9].
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    to_cnt_d   = to_cnt_q;
    frame_done = 1'b0;
    case (state_q)
      IDLE: begin
        to_cnt_d = '0;
        if (fall) begin
          shift_d   = {bit_in, shift_q[9:1]};
          bit_cnt_d = 4'd1;
          state_d   = RECV;
        end
      end
      RECV: begin
        if (fall) begin
          to_cnt_d = '0;
          if (bit_cnt_q == 4'd10) begin
            frame_done = 1'b1;
            bit_cnt_d  = 4'd0;
            state_d    = IDLE;
          end else begin
            shift_d   = {bit_in, shift_q[9:1]};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end else if (to_cnt_q == TW'(TIMEOUT - 1)) begin
          to_cnt_d  = '0;
          bit_cnt_d = 4'd0;
          state_d   = IDLE;
        end else begin
          to_cnt_d = to_cnt_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign frame_ok  = frame_done & ~shift_q[0] & bit_in & (^shift_q[9:1]);
  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(FIFO_DEPTH));
  assign pop       = sel & re & ~addr[2] & ~empty;
  assign push      = frame_ok & (~full | pop);
  assign status_rd = sel & re & addr[2];

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
    // A flag-setting event in the same cycle as a STATUS read wins.
    ovf_d  = (frame_ok & full & ~pop) | (ovf_q & ~status_rd);
    ferr_d = (frame_done & ~frame_ok) | (ferr_q & ~status_rd);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      to_cnt_q  <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      to_cnt_q  <= to_cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      ferr_q    <= ferr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= shift_q[8:1];
  end

  always_comb begin
    dout = '0;
    if (sel) begin
      if (addr[2]) dout = {19'b0, 5'(count_q), 4'b0, ferr_q, ovf_q, full, ~empty};
      else if (!empty) dout = {24'b0, mem_q[rd_ptr_q]};
    end
  end

endmodule

// File: tb/tb_ps2_kbd.sv
// Self-checking bench for ps2_kbd: directed scenarios plus randomized traffic
// checked against a queue-based model of the keyboard port.
module tb_ps2_kbd;
  localparam int DEPTH = 8;
  localparam int TMO   = 120;

  logic        clk = 1'b0;
  logic        rst, ps2_clk, ps2_data, sel, re;
  logic [31:0] addr, dout;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [7:0] mq[$];
  bit         m_ovf, m_ferr;

  always #5 clk = ~clk;

  ps2_kbd #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .sel(sel), .re(re), .addr(addr), .dout(dout)
  );

  initial begin
    #10_000_000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s      = '0;
    s[0]   = (mq.size() != 0);
    s[1]   = (mq.size() == DEPTH);
    s[2]   = m_ovf;
    s[3]   = m_ferr;
    s[12:8] = 5'(mq.size());
    return s;
  endfunction

  function automatic logic [31:0] exp_data();
    return (mq.size() != 0) ? {24'b0, mq[0]} : 32'h0;
  endfunction

  function automatic void model_frame(input logic [7:0] d, input bit good);
    if (!good)                   m_ferr = 1'b1;
    else if (mq.size() == DEPTH) m_ovf  = 1'b1;
    else                         mq.push_back(d);
  endfunction

  task automatic rd_status(input string tag);
    @(negedge clk); sel = 1'b1; re = 1'b1; addr = 32'h4;
    #1 chk(tag, dout, exp_status());
    $display("[TB] STATUS read %s dout=0x%08h", tag, dout);
    m_ovf = 1'b0; m_ferr = 1'b0;
    @(negedge clk); sel = 1'b0; re = 1'b0; addr = '0;
  endtask

  task automatic rd_data(input string tag);
    @(negedge clk); sel = 1'b1; re = 1'b1; addr = 32'h0;
    #1 chk(tag, dout, exp_data());
    $display("[TB] DATA read %s dout=0x%08h", tag, dout);
    if (mq.size() != 0) void'(mq.pop_front());
    @(negedge clk); sel = 1'b0; re = 1'b0; addr = '0;
  endtask

  // Observes a register with re low or sel low; neither may change state.
  task automatic peek(input bit s, input bit a2);
    @(negedge clk); sel = s; re = ~s; addr = {29'b0, a2, 2'b0};
    #1 chk(s ? (a2 ? "peek_status" : "peek_data") : "unsel_zero", dout,
           !s ? 32'h0 : (a2 ? exp_status() : exp_data()));
    $display("[TB] peek sel=%0d addr2=%0d dout=0x%08h", s, a2, dout);
    @(negedge clk); sel = 1'b0; re = 1'b0; addr = '0;
  endtask

  // One PS/2 bit; optionally issues a DATA read in the cycle the edge is seen.
  task automatic ps2_bit(input logic b, input bit rd_at_edge);
    @(negedge clk); ps2_data = b;
    repeat (4) @(negedge clk);
    ps2_clk = 1'b0;
    if (rd_at_edge) begin
      @(posedge clk); @(posedge clk); @(negedge clk);
      sel = 1'b1; re = 1'b1; addr = 32'h0;
      #1 chk("pop_at_edge", dout, exp_data());
      $display("[TB] DATA read at 11th edge dout=0x%08h", dout);
      if (mq.size() != 0) void'(mq.pop_front());
      @(negedge clk); sel = 1'b0; re = 1'b0;
      repeat (5) @(negedge clk);
    end else begin
      repeat (8) @(negedge clk);
    end
    ps2_clk = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit good, input int nbits, input bit rd_last);
    logic [10:0] f;
    logic        par;
    par = ~^d;
    if (!good) par = ~par;
    f = {1'b1, par, d, 1'b0};
    for (int i = 0; i < nbits; i++) ps2_bit(f[i], rd_last && (i == 10));
    if (nbits == 11) model_frame(d, good);
    $display("[TB] frame 0x%02h good=%0d bits=%0d", d, good, nbits);
  endtask

  initial begin
    rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; sel = 1'b0; re = 1'b0; addr = '0;
    m_ovf = 1'b0; m_ferr = 1'b0;
    repeat (3) @(negedge clk);
    chk("dout_in_reset", dout, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("dout_after_reset", dout, 32'h0);
    rd_status("status_after_reset");

    // Single valid frame, then the FIFO drains.
    send_frame(8'h1C, 1'b1, 11, 1'b0);
    rd_status("valid_1c_status");
    rd_data("valid_1c_data");
    rd_status("valid_1c_empty");

    // Parity error.
    send_frame(8'h1C, 1'b0, 11, 1'b0);
    rd_status("parity_err_status");
    rd_status("parity_err_cleared");

    // Overflow with nine frames, then drain.
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b1, 11, 1'b0);
    rd_status("overflow_status");
    for (int i = 0; i < DEPTH; i++) rd_data("overflow_drain");
    rd_status("overflow_cleared");

    // Full FIFO with a pop coinciding with the 11th edge.
    for (int i = 0; i < DEPTH; i++) send_frame(8'h60 + 8'(i), 1'b1, 11, 1'b0);
    send_frame(8'h55, 1'b1, 11, 1'b1);
    rd_status("full_pop_push_status");
    for (int i = 0; i < DEPTH; i++) rd_data("full_pop_push_drain");
    rd_status("full_pop_push_empty");

    // Partial frame abandoned by timeout.
    send_frame(8'hA5, 1'b1, 5, 1'b0);
    repeat (TMO + 1) @(negedge clk);
    send_frame(8'h2A, 1'b1, 11, 1'b0);
    rd_status("timeout_status");
    rd_data("timeout_data");

    // Reset mid-frame.
    send_frame(8'hC3, 1'b1, 6, 1'b0);
    @(negedge clk); rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("dout_mid_reset", dout, 32'h0);
    rst = 1'b0;
    mq.delete(); m_ovf = 1'b0; m_ferr = 1'b0;
    send_frame(8'h3B, 1'b1, 11, 1'b0);
    rd_status("rst_midframe_status");
    rd_data("rst_midframe_data");
    rd_status("rst_midframe_empty");

    // Randomized traffic.
    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 6))
        0, 1: send_frame(8'($urandom), $urandom_range(0, 7) != 0, 11, 1'b0);
        2:    rd_data("rand_data");
        3:    rd_status("rand_status");
        4:    peek(1'b1, 1'($urandom_range(0, 1)));
        5:    peek(1'b0, 1'($urandom_range(0, 1)));
        default: begin
          send_frame(8'($urandom), 1'b1, $urandom_range(1, 10), 1'b0);
          repeat (TMO + 2) @(negedge clk);
        end
      endcase
    end
    rd_status("final_status");
    while (mq.size() != 0) rd_data("final_drain");
    rd_status("final_empty");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
